// File: rtl/instr_fetch_resp_pkg.sv
// Shared definitions for the instruction fetch responder.
package instr_fetch_resp_pkg;

  // Responder FSM states: waiting for a request, counting wait states, presenting a response.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } fetch_state_e;

  // Default instruction word width.
  localparam int unsigned IlenDefault = 32;

  // Wait-state counter width, enough for 0..15 wait states.
  localparam int unsigned CntW = 4;

endpackage

// File: rtl/instr_mem_array.sv
// Instruction word storage: synchronous write, registered read with read-enable.
module instr_mem_array #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32,
  parameter int unsigned Aw    = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [Aw-1:0]    waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic             rclr_i,
  input  logic [Aw-1:0]    raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  // Storage array; contents survive reset, write gating is done by the parent.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register: loads old contents on a same-edge write; rclr_i forces zero for bad addresses.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rclr_i ? '0 : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_fetch_resp.sv
// Instruction-memory responder: accepts a fetch address, returns the word after WaitStates cycles.
module instr_fetch_resp
  import instr_fetch_resp_pkg::*;
#(
  parameter int unsigned Xlen       = 4,
  parameter int unsigned Ilen       = IlenDefault,
  parameter int unsigned Depth      = 4,
  parameter int unsigned WaitStates = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  input  logic [Xlen-1:0] req_addr,
  output logic            req_ready,
  output logic            resp_valid,
  output logic [Ilen-1:0] resp_instr,
  output logic            resp_err,
  input  logic            resp_ready,
  input  logic            wr_en,
  input  logic [Xlen-1:0] wr_addr,
  input  logic [Ilen-1:0] wr_data
);

  localparam int unsigned MemAw = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntW-1:0] WaitInit = (WaitStates == 0) ? '0 : CntW'(WaitStates - 1);

  fetch_state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [Xlen-1:0] addr_q, addr_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_err_q, resp_err_d;

  logic [Xlen-1:0] rd_addr;
  logic            rd_bad;
  logic            rd_en;
  logic            wr_ok;

  // A zero-wait accept reads the live request address; otherwise the captured one.
  assign rd_addr = (state_q == StIdle) ? req_addr : addr_q;
  // Misaligned or past the end of the store; the full word index is compared.
  assign rd_bad  = (rd_addr[1:0] != 2'b00) || (32'(rd_addr[Xlen-1:2]) >= Depth);
  assign wr_ok   = rstn && wr_en && (wr_addr[1:0] == 2'b00) && (32'(wr_addr[Xlen-1:2]) < Depth);

  // Next-state logic for the fetch FSM, wait counter and registered response flags.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    rd_en        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d = req_addr;
          if (WaitStates == 0) begin
            state_d      = StResp;
            rd_en        = 1'b1;
            resp_valid_d = 1'b1;
            resp_err_d   = rd_bad;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d      = StResp;
          rd_en        = 1'b1;
          resp_valid_d = 1'b1;
          resp_err_d   = rd_bad;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        // Response data and error stay as-is after the handshake.
        if (resp_ready) begin
          state_d      = StIdle;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and registered outputs; synchronous reset drops any in-flight fetch.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      addr_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  instr_mem_array #(
    .Depth (Depth),
    .Width (Ilen),
    .Aw    (MemAw)
  ) u_mem (
    .clk_i   (clk),
    .rst_ni  (rstn),
    .we_i    (wr_ok),
    .waddr_i (wr_addr[MemAw+1:2]),
    .wdata_i (wr_data),
    .re_i    (rd_en),
    .rclr_i  (rd_bad),
    .raddr_i (rd_addr[MemAw+1:2]),
    .rdata_o (resp_instr)
  );

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_instr_fetch_resp.sv
// Bench for instr_fetch_resp: three instances with 1, 3 and 0 wait states, 8-bit addresses.
module tb_instr_fetch_resp;

  localparam int unsigned NDut = 3;
  localparam int unsigned Xw   = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid  [NDut];
  logic [Xw-1:0] req_addr   [NDut];
  logic          req_ready  [NDut];
  logic          resp_valid [NDut];
  logic [31:0]   resp_instr [NDut];
  logic          resp_err   [NDut];
  logic          resp_ready [NDut];
  logic          wr_en      [NDut];
  logic [Xw-1:0] wr_addr    [NDut];
  logic [31:0]   wr_data    [NDut];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    instr_fetch_resp #(
      .Xlen       (Xw),
      .Ilen       (32),
      .Depth      (4),
      .WaitStates ((g == 0) ? 1 : (g == 1) ? 3 : 0)
    ) u_dut (
      .clk        (clk),
      .rstn       (rstn),
      .req_valid  (req_valid[g]),
      .req_addr   (req_addr[g]),
      .req_ready  (req_ready[g]),
      .resp_valid (resp_valid[g]),
      .resp_instr (resp_instr[g]),
      .resp_err   (resp_err[g]),
      .resp_ready (resp_ready[g]),
      .wr_en      (wr_en[g]),
      .wr_addr    (wr_addr[g]),
      .wr_data    (wr_data[g])
    );
  end

  typedef struct {
    int          dut;
    logic [7:0]  addr;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  vec_t vecs [12];

  function automatic int ws_of(input int d);
    case (d)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_all(input logic [7:0] a, input logic [31:0] v);
    for (int d = 0; d < NDut; d++) begin
      wr_en[d]   = 1'b1;
      wr_addr[d] = a;
      wr_data[d] = v;
    end
    tick();
    for (int d = 0; d < NDut; d++) wr_en[d] = 1'b0;
  endtask

  // One complete fetch with resp_ready held high; checks latency, data, error and handshake.
  task automatic fetch(input int d, input logic [7:0] a, input logic [31:0] ei, input logic ee);
    int n;
    n = 0;
    req_valid[d]  = 1'b1;
    req_addr[d]   = a;
    resp_ready[d] = 1'b1;
    tick();
    req_valid[d] = 1'b0;
    while (resp_valid[d] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check($sformatf("latency d%0d a%02h", d, a), n, ws_of(d));
    check($sformatf("instr d%0d a%02h", d, a), resp_instr[d], ei);
    check($sformatf("err d%0d a%02h", d, a), {31'd0, resp_err[d]}, {31'd0, ee});
    check($sformatf("ready_busy d%0d a%02h", d, a), {31'd0, req_ready[d]}, 32'd0);
    tick();
    check($sformatf("valid_drop d%0d a%02h", d, a), {31'd0, resp_valid[d]}, 32'd0);
    check($sformatf("ready_back d%0d a%02h", d, a), {31'd0, req_ready[d]}, 32'd1);
  endtask

  initial begin
    int seen;
    rstn = 1'b0;
    for (int d = 0; d < NDut; d++) begin
      req_valid[d]  = 1'b0;
      req_addr[d]   = '0;
      resp_ready[d] = 1'b0;
      wr_en[d]      = 1'b0;
      wr_addr[d]    = '0;
      wr_data[d]    = '0;
    end
    tick();
    tick();

    for (int d = 0; d < NDut; d++) begin
      check($sformatf("rst_ready d%0d", d), {31'd0, req_ready[d]}, 32'd1);
      check($sformatf("rst_valid d%0d", d), {31'd0, resp_valid[d]}, 32'd0);
      check($sformatf("rst_instr d%0d", d), resp_instr[d], 32'd0);
      check($sformatf("rst_err d%0d", d), {31'd0, resp_err[d]}, 32'd0);
    end
    rstn = 1'b1;
    tick();

    // Preload, then writes that must be dropped (out of range or misaligned).
    write_all(8'h00, 32'h0000_0013);
    write_all(8'h04, 32'h0010_0093);
    write_all(8'h08, 32'h1111_1111);
    write_all(8'h0C, 32'h2222_2222);
    write_all(8'h10, 32'hBAD0_BAD0);
    write_all(8'h01, 32'hBAD1_BAD1);
    write_all(8'h0E, 32'hBAD2_BAD2);
    write_all(8'h40, 32'hBAD3_BAD3);

    vecs[0]  = '{0, 8'h04, 32'h0010_0093, 1'b0};
    vecs[1]  = '{0, 8'h02, 32'h0000_0000, 1'b1};
    vecs[2]  = '{0, 8'h00, 32'h0000_0013, 1'b0};
    vecs[3]  = '{0, 8'h10, 32'h0000_0000, 1'b1};
    vecs[4]  = '{0, 8'h0C, 32'h2222_2222, 1'b0};
    vecs[5]  = '{0, 8'hFC, 32'h0000_0000, 1'b1};
    vecs[6]  = '{1, 8'h08, 32'h1111_1111, 1'b0};
    vecs[7]  = '{1, 8'h01, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1, 8'h04, 32'h0010_0093, 1'b0};
    vecs[9]  = '{2, 8'h00, 32'h0000_0013, 1'b0};
    vecs[10] = '{2, 8'h11, 32'h0000_0000, 1'b1};
    vecs[11] = '{2, 8'h0C, 32'h2222_2222, 1'b0};
    for (int i = 0; i < 12; i++) begin
      fetch(vecs[i].dut, vecs[i].addr, vecs[i].instr, vecs[i].err);
    end

    // Backpressure on d0; a held request must not be taken until one cycle after release.
    req_valid[0]  = 1'b1;
    req_addr[0]   = 8'h00;
    resp_ready[0] = 1'b0;
    tick();
    req_addr[0] = 8'h04;
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid c%0d", i), {31'd0, resp_valid[0]}, 32'd1);
      check($sformatf("bp_instr c%0d", i), resp_instr[0], 32'h0000_0013);
      check($sformatf("bp_ready c%0d", i), {31'd0, req_ready[0]}, 32'd0);
      tick();
    end
    resp_ready[0] = 1'b1;
    tick();
    check("bp_release_valid", {31'd0, resp_valid[0]}, 32'd0);
    check("bp_release_ready", {31'd0, req_ready[0]}, 32'd1);
    check("bp_hold_instr", resp_instr[0], 32'h0000_0013);
    tick();
    check("bp_next_accept", {31'd0, req_ready[0]}, 32'd0);
    req_valid[0] = 1'b0;
    tick();
    check("bp_next_valid", {31'd0, resp_valid[0]}, 32'd1);
    check("bp_next_instr", resp_instr[0], 32'h0010_0093);
    tick();
    check("bp_next_drop", {31'd0, resp_valid[0]}, 32'd0);

    // d1 (3 wait states): write in the first WAIT cycle is seen.
    req_valid[1]  = 1'b1;
    req_addr[1]   = 8'h08;
    resp_ready[1] = 1'b1;
    tick();
    req_valid[1] = 1'b0;
    wr_en[1]     = 1'b1;
    wr_addr[1]   = 8'h08;
    wr_data[1]   = 32'hDEAD_BEEF;
    tick();
    wr_en[1] = 1'b0;
    tick();
    tick();
    check("wwait_valid", {31'd0, resp_valid[1]}, 32'd1);
    check("wwait_instr", resp_instr[1], 32'hDEAD_BEEF);
    tick();
    check("wwait_drop", {31'd0, resp_valid[1]}, 32'd0);

    // Same, but the write lands on the RESP-entry edge: old data returned.
    req_valid[1] = 1'b1;
    tick();
    req_valid[1] = 1'b0;
    tick();
    tick();
    wr_en[1]   = 1'b1;
    wr_data[1] = 32'hCAFE_F00D;
    tick();
    wr_en[1] = 1'b0;
    check("wcoll_valid", {31'd0, resp_valid[1]}, 32'd1);
    check("wcoll_instr", resp_instr[1], 32'hDEAD_BEEF);
    tick();
    fetch(1, 8'h08, 32'hCAFE_F00D, 1'b0);

    // Reset during d1's WAIT; write and request presented under reset are ignored.
    req_valid[1] = 1'b1;
    req_addr[1]  = 8'h04;
    tick();
    req_valid[1] = 1'b0;
    rstn         = 1'b0;
    wr_en[1]     = 1'b1;
    wr_addr[1]   = 8'h04;
    wr_data[1]   = 32'hBADB_AD00;
    req_valid[2] = 1'b1;
    req_addr[2]  = 8'h00;
    tick();
    rstn         = 1'b1;
    wr_en[1]     = 1'b0;
    req_valid[2] = 1'b0;
    check("mrst_ready_d1", {31'd0, req_ready[1]}, 32'd1);
    check("mrst_valid_d1", {31'd0, resp_valid[1]}, 32'd0);
    check("mrst_instr_d1", resp_instr[1], 32'd0);
    check("mrst_ready_d2", {31'd0, req_ready[2]}, 32'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid[1] === 1'b1 || resp_valid[2] === 1'b1) seen++;
      tick();
    end
    check("mrst_no_resp", seen, 0);
    fetch(1, 8'h04, 32'h0010_0093, 1'b0);

    // d2 (0 wait states): back-to-back requests yield one response every 2 cycles.
    req_valid[2]  = 1'b1;
    req_addr[2]   = 8'h04;
    resp_ready[2] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("b2b_valid k%0d", k), {31'd0, resp_valid[2]}, 32'(k % 2));
      if (k % 2 == 1) check($sformatf("b2b_instr k%0d", k), resp_instr[2], 32'h0010_0093);
    end
    req_valid[2] = 1'b0;
    tick();
    check("b2b_idle", {31'd0, resp_valid[2]}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
